mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//  Elastic MEM->WB pipeline register for the vector processor; successor to the fixed MEM-stage register.
//  Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and bubble gating.
//  Also adds destination-hazard compare outputs for forwarding, an end-of-program halt and a stall counter.
//  Sits between the memory-access stage and register-file write-back.
// PARAMETERS
//  REGI_BITS  4   integer register index width
//  VECT_BITS  2   vector register / memo_res index width
//  ELEM_SIZE  8   bits per vector element
//  VECT_SIZE  8   elements per vector; data width DW = ELEM_SIZE*VECT_SIZE
//  JUMP_BITS  10  jump address width
//  CNT_BITS   16  stall counter width
// PORTS
//  clk_i        in   1          clock, all state on posedge
//  rst_i        in   1          synchronous active-high reset
//  valid_i      in   1          upstream entry valid
//  ready_o      out  1          stage can accept (registered: !skid_full & !end_seen)
//  data_i       in   DW         result data (int_rd)
//  ctrl_i       in   mem_ctrl_t control bundle (flags, jumpAddress, dests, memo_res, write enables)
//  valid_o      out  1          output entry valid
//  ready_i      in   1          downstream accepts
//  data_o       out  DW         head-entry data
//  ctrl_o       out  mem_ctrl_t head-entry control, gated (see below)
//  flush_i      in   1          discard all held entries
//  src_int_i    in   REGI_BITS  integer source index probed by decode
//  src_vec_i    in   VECT_BITS  vector source index probed by decode
//  hz_int_o     out  1          integer RAW hit against any held entry
//  hz_vec_o     out  1          vector RAW hit against any held entry
//  end_seen_o   out  1          flagEnd entry has retired; stage halted
//  stall_cnt_o  out  CNT_BITS   saturating count of backpressured cycles
// BEHAVIOUR
//  Reset: all entries invalid; valid_o=0, ready_o=1, end_seen_o=0, stall_cnt_o=0.
//  Reset: data_o=0 and ctrl_o=0, with ctrl_o.flagNop=1.
//  Storage: head reg H + skid reg S; accept = valid_i & ready_o; retire = valid_o & ready_i.
//  Latency 1 cycle: an entry accepted into an empty stage appears on data_o/ctrl_o next cycle.
//  Ordering strictly FIFO. Accept with H busy and not retiring writes S; S moves to H on retire.
//  Full throughput: accept+retire in the same cycle with S empty updates H directly, 1 entry/cycle.
//  ready_o deasserts the cycle after S fills; no entry is ever dropped or duplicated.
//  Bubble gating: when valid_o=0, ctrl_o write enables are forced 0 and flagNop=1; data_o holds last value.
//  Gated write enables: enableReg, enableJump, flagMemRead, flagMemWrite, writeResultInt, writeResultV, flagEnd.
//  flush_i: H and S invalid next cycle; a simultaneous accept is discarded (flush wins).
//  flush_i: stall_cnt_o and end_seen_o are unaffected.
//  end_seen: set when a retiring entry has ctrl.flagEnd=1; cleared only by rst_i.
//  While end_seen=1, ready_o=0. Entries already held still drain normally.
//  hz_int_o=1 when any valid entry has writeResultInt=1 and intRegDest==src_int_i (combinational on state).
//  hz_vec_o: same rule using writeResultV and vecRegDest vs src_vec_i.
//  stall_cnt_o increments when valid_o & !ready_i, saturating at all-ones.
//  rst_i asserted mid-transfer discards all entries; no partial state survives.
// STRUCTURE
//  Package mem_pipe_pkg: mem_ctrl_t struct packed (enableReg, enableJump, flagMemRead, flagMemWrite,
//  flagEnd, flagNop, jumpAddress[JUMP_BITS], intRegDest, vecRegDest, memo_res, writeResultInt,
//  writeResultV); constant MEM_CTRL_NOP.
//  Sub-module skid_buf2 (generic 2-entry valid/ready skid over a packed payload).
//  The top adds gating, hazard compare, end latch and counter.
// TESTING
//  Stream 8 entries, ready_i=1 -> 8 outputs in order, 1/cycle, first 1 cycle after first accept.
//  ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0 after S fills; nothing lost; stall_cnt_o=3.
//  flush_i with H,S full plus valid_i=1 -> valid_o=0 next cycle, ctrl_o.flagNop=1, all enables 0.
//  Held entry intRegDest=5, writeResultInt=1; src_int_i=5 -> hz_int_o=1; src_int_i=6 -> 0.
//  Retire entry with flagEnd=1 -> end_seen_o=1, ready_o=0 until rst_i.
//  rst_i with 2 entries held -> next cycle valid_o=0, ready_o=1, counters 0.

Source files
------------

// File: rtl/mem_pipe_pkg.sv
// Shared types for the MEM->WB elastic pipeline register.
//   mem_ctrl_t   : control bundle carried alongside each result
//   mem_entry_t  : one stored pipeline entry (data + control)
//   MEM_CTRL_NOP : control value presented when no entry is valid
//   gate_ctrl    : forces write enables off and flagNop on for a bubble
package mem_pipe_pkg;

  localparam int unsigned REGI_BITS = 4;
  localparam int unsigned VECT_BITS = 2;
  localparam int unsigned ELEM_SIZE = 8;
  localparam int unsigned VECT_SIZE = 8;
  localparam int unsigned DW        = ELEM_SIZE * VECT_SIZE;
  localparam int unsigned JUMP_BITS = 10;
  localparam int unsigned CNT_BITS  = 16;

  typedef struct packed {
    logic                 enableReg;
    logic                 enableJump;
    logic                 flagMemRead;
    logic                 flagMemWrite;
    logic                 flagEnd;
    logic                 flagNop;
    logic [JUMP_BITS-1:0] jumpAddress;
    logic [REGI_BITS-1:0] intRegDest;
    logic [VECT_BITS-1:0] vecRegDest;
    logic [VECT_BITS-1:0] memo_res;
    logic                 writeResultInt;
    logic                 writeResultV;
  } mem_ctrl_t;

  typedef struct packed {
    logic [DW-1:0] data;
    mem_ctrl_t     ctrl;
  } mem_entry_t;

  localparam mem_ctrl_t MEM_CTRL_NOP = '{
    enableReg:      1'b0,
    enableJump:     1'b0,
    flagMemRead:    1'b0,
    flagMemWrite:   1'b0,
    flagEnd:        1'b0,
    flagNop:        1'b1,
    jumpAddress:    '0,
    intRegDest:     '0,
    vecRegDest:     '0,
    memo_res:       '0,
    writeResultInt: 1'b0,
    writeResultV:   1'b0
  };

  // Non-enable fields pass through untouched so a bubble still shows the last entry's addresses.
  function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t c, input logic valid);
    mem_ctrl_t g;
    g = c;
    if (!valid) begin
      g.enableReg      = 1'b0;
      g.enableJump     = 1'b0;
      g.flagMemRead    = 1'b0;
      g.flagMemWrite   = 1'b0;
      g.writeResultInt = 1'b0;
      g.writeResultV   = 1'b0;
      g.flagEnd        = 1'b0;
      g.flagNop        = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// Valid/ready channel carrying one MEM-stage result.
//   valid : entry valid (source -> sink)
//   ready : sink accepts (sink -> source)
//   data  : result data, DW bits
//   ctrl  : control bundle
// master = producer side, slave = consumer side.
interface mem_stage_pipe_if;
  import mem_pipe_pkg::*;

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  mem_ctrl_t     ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer over a packed payload.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             invalidate both entries (wins over a simultaneous accept)
//   block_i             hold in_ready_o low (entries still drain)
//   in_valid_i/in_ready_o/in_data_i     upstream side
//   out_valid_o/out_ready_i/out_data_o  downstream side (head entry)
//   skid_valid_o/skid_data_o            second entry, exposed for hazard checks
module skid_buf2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             block_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             skid_valid_o,
  output logic [Width-1:0] skid_data_o
);

  logic             head_valid_q, head_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             accept, retire;

  // Ready depends only on state, so there is no valid->ready combinational path.
  assign in_ready_o = ~skid_valid_q & ~block_i;
  assign accept     = in_valid_i & in_ready_o;
  assign retire     = head_valid_q & out_ready_i;

  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_d       = head_q;
    skid_d       = skid_q;
    if (flush_i) begin
      // Payload registers keep their contents so data_o holds during the bubble.
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || retire) begin
      // Head is free this cycle: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_d       = in_data_i;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid_o  = head_valid_q;
  assign out_data_o   = head_q;
  assign skid_valid_o = skid_valid_q;
  assign skid_data_o  = skid_q;

endmodule

// File: rtl/mem_stage_pipe.sv
// Elastic MEM->WB pipeline register.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   up  (slave)           results from the memory-access stage
//   dn  (master)          results to write-back; ctrl gated to a NOP when invalid
//   flush_i               discard all held entries
//   src_int_i, src_vec_i  source indices probed by decode
//   hz_int_o, hz_vec_o    RAW hit against any held entry
//   end_seen_o            a flagEnd entry has retired; intake halted until reset
//   stall_cnt_o           saturating count of backpressured cycles
module mem_stage_pipe
  import mem_pipe_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_stage_pipe_if.slave      up,
  mem_stage_pipe_if.master     dn,
  input  logic                 flush_i,
  input  logic [REGI_BITS-1:0] src_int_i,
  input  logic [VECT_BITS-1:0] src_vec_i,
  output logic                 hz_int_o,
  output logic                 hz_vec_o,
  output logic                 end_seen_o,
  output logic [CNT_BITS-1:0]  stall_cnt_o
);

  mem_entry_t                in_entry, head_entry, skid_entry;
  logic                      head_valid, skid_valid;
  logic                      retire;
  logic                      end_seen_q;
  logic [CNT_BITS-1:0]       stall_cnt_q;

  assign in_entry = '{data: up.data, ctrl: up.ctrl};

  skid_buf2 #(
    .Width($bits(mem_entry_t))
  ) u_skid (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .block_i      (end_seen_q),
    .in_valid_i   (up.valid),
    .in_ready_o   (up.ready),
    .in_data_i    (in_entry),
    .out_valid_o  (head_valid),
    .out_ready_i  (dn.ready),
    .out_data_o   (head_entry),
    .skid_valid_o (skid_valid),
    .skid_data_o  (skid_entry)
  );

  assign retire   = head_valid & dn.ready;
  assign dn.valid = head_valid;
  assign dn.data  = head_entry.data;
  assign dn.ctrl  = gate_ctrl(head_entry.ctrl, head_valid);

  assign hz_int_o =
      (head_valid & head_entry.ctrl.writeResultInt & (head_entry.ctrl.intRegDest == src_int_i)) |
      (skid_valid & skid_entry.ctrl.writeResultInt & (skid_entry.ctrl.intRegDest == src_int_i));
  assign hz_vec_o =
      (head_valid & head_entry.ctrl.writeResultV & (head_entry.ctrl.vecRegDest == src_vec_i)) |
      (skid_valid & skid_entry.ctrl.writeResultV & (skid_entry.ctrl.vecRegDest == src_vec_i));

  // Neither the end latch nor the stall counter reacts to flush_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      end_seen_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (retire && head_entry.ctrl.flagEnd) begin
        end_seen_q <= 1'b1;
      end
      if (head_valid && !dn.ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
      end
    end
  end

  assign end_seen_o  = end_seen_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
module tb_mem_stage_pipe;
  import mem_pipe_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [REGI_BITS-1:0] src_int;
  logic [VECT_BITS-1:0] src_vec;
  logic                 hz_int, hz_vec, end_seen;
  logic [CNT_BITS-1:0]  stall_cnt;

  always #5 clk = ~clk;

  mem_stage_pipe_if up_if ();
  mem_stage_pipe_if dn_if ();

  mem_stage_pipe dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .up          (up_if),
    .dn          (dn_if),
    .flush_i     (flush),
    .src_int_i   (src_int),
    .src_vec_i   (src_vec),
    .hz_int_o    (hz_int),
    .hz_vec_o    (hz_vec),
    .end_seen_o  (end_seen),
    .stall_cnt_o (stall_cnt)
  );

  int         checks = 0;
  int         failures = 0;
  int         n_retired = 0;
  mem_entry_t sb_q[$];
  mem_entry_t mon_e;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected bubble view of a control word, built independently of the RTL.
  function automatic mem_ctrl_t bubble_of(input mem_ctrl_t c);
    mem_ctrl_t r;
    r = c;
    {r.enableReg, r.enableJump, r.flagMemRead, r.flagMemWrite} = 4'b0000;
    {r.writeResultInt, r.writeResultV, r.flagEnd} = 3'b000;
    r.flagNop = 1'b1;
    return r;
  endfunction

  function automatic mem_entry_t rand_entry();
    mem_entry_t  e;
    logic [31:0] r;
    r       = $urandom;
    e.data  = {$urandom, $urandom};
    e.ctrl  = r[$bits(mem_ctrl_t)-1:0];
    e.ctrl.flagEnd = 1'b0;
    return e;
  endfunction

  // Scoreboard: pop/compare on retire, push on accept, drop everything on flush/reset.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (dn_if.valid && dn_if.ready) begin
        check_eq("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_eq("out_data", 128'(dn_if.data), 128'(mon_e.data));
          check_eq("out_ctrl", 128'(dn_if.ctrl), 128'(mon_e.ctrl));
        end
        n_retired++;
      end
      if (flush) sb_q.delete();
      else if (up_if.valid && up_if.ready) sb_q.push_back('{data: up_if.data, ctrl: up_if.ctrl});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_entry_t e);
    up_if.valid = 1'b1;
    up_if.data  = e.data;
    up_if.ctrl  = e.ctrl;
  endtask

  task automatic wait_drain(input string tag);
    dn_if.ready = 1'b1;
    for (int i = 0; i < 20 && (sb_q.size() != 0 || dn_if.valid); i++) step();
    check_eq(tag, 128'(sb_q.size()), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_entry_t e;
    mem_ctrl_t  exp_ctrl;
    logic [DW-1:0] exp_data;
    int base;

    rst = 1'b1; flush = 1'b0; src_int = '0; src_vec = '0;
    up_if.valid = 1'b0; up_if.data = '0; up_if.ctrl = '0; dn_if.ready = 1'b1;
    step(); step();
    @(negedge clk);
    exp_ctrl = '0; exp_ctrl.flagNop = 1'b1;
    check_eq("rst_valid", 128'(dn_if.valid), 128'(0));
    check_eq("rst_ready", 128'(up_if.ready), 128'(1));
    check_eq("rst_end", 128'(end_seen), 128'(0));
    check_eq("rst_stall", 128'(stall_cnt), 128'(0));
    check_eq("rst_data", 128'(dn_if.data), 128'(0));
    check_eq("rst_ctrl", 128'(dn_if.ctrl), 128'(exp_ctrl));
    step();
    rst = 1'b0;

    // Stream 8 entries at full rate.
    base = n_retired;
    for (int i = 0; i < 8; i++) begin
      drive(rand_entry());
      @(negedge clk);
      if (i == 0) check_eq("lat_empty", 128'(dn_if.valid), 128'(0));
      if (i == 1) check_eq("lat_first", 128'(dn_if.valid), 128'(1));
      check_eq("stream_ready", 128'(up_if.ready), 128'(1));
      step();
    end
    up_if.valid = 1'b0;
    @(negedge clk);
    step();
    check_eq("stream_count", 128'(n_retired - base), 128'(8));
    check_eq("stream_sb", 128'(sb_q.size()), 128'(0));

    // Backpressure for 3 valid cycles.
    dn_if.ready = 1'b0;
    drive(rand_entry());
    @(negedge clk);
    check_eq("stall_pre", 128'(dn_if.valid), 128'(0));
    step();
    drive(rand_entry());
    step();
    drive(rand_entry());
    @(negedge clk);
    check_eq("stall_ready", 128'(up_if.ready), 128'(0));
    step();
    @(negedge clk);
    check_eq("stall_ready2", 128'(up_if.ready), 128'(0));
    step();
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    @(negedge clk);
    check_eq("stall_cnt", 128'(stall_cnt), 128'(3));
    wait_drain("stall_drain");

    // Flush with head and skid full plus an offered entry.
    dn_if.ready = 1'b0;
    drive(rand_entry());
    step();
    drive(rand_entry());
    step();
    exp_ctrl = bubble_of(sb_q[0].ctrl);
    exp_data = sb_q[0].data;
    flush = 1'b1;
    drive(rand_entry());
    step();
    flush = 1'b0;
    up_if.valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", 128'(dn_if.valid), 128'(0));
    check_eq("flush_ctrl", 128'(dn_if.ctrl), 128'(exp_ctrl));
    check_eq("flush_data_hold", 128'(dn_if.data), 128'(exp_data));
    step();

    // Flush wins over a simultaneous accept.
    drive(rand_entry());
    step();
    flush = 1'b1;
    drive(rand_entry());
    step();
    flush = 1'b0;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    @(negedge clk);
    check_eq("flush_accept", 128'(dn_if.valid), 128'(0));
    step(); step();
    check_eq("flush_empty", 128'(dn_if.valid), 128'(0));

    // Hazard compares.
    dn_if.ready = 1'b0;
    e = rand_entry();
    e.ctrl.intRegDest = 4'd5; e.ctrl.writeResultInt = 1'b1;
    e.ctrl.vecRegDest = 2'd2; e.ctrl.writeResultV = 1'b1;
    drive(e);
    step();
    e = rand_entry();
    e.ctrl.intRegDest = 4'd9; e.ctrl.writeResultInt = 1'b1;
    e.ctrl.vecRegDest = 2'd1; e.ctrl.writeResultV = 1'b0;
    drive(e);
    step();
    up_if.valid = 1'b0;
    src_int = 4'd5; src_vec = 2'd2;
    @(negedge clk);
    check_eq("hz_int_hit", 128'(hz_int), 128'(1));
    check_eq("hz_vec_hit", 128'(hz_vec), 128'(1));
    step();
    src_int = 4'd6; src_vec = 2'd1;
    @(negedge clk);
    check_eq("hz_int_miss", 128'(hz_int), 128'(0));
    check_eq("hz_vec_gated", 128'(hz_vec), 128'(0));
    step();
    src_int = 4'd9;
    @(negedge clk);
    check_eq("hz_int_skid", 128'(hz_int), 128'(1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    src_int = 4'd5; src_vec = 2'd2;
    @(negedge clk);
    check_eq("hz_int_flushed", 128'(hz_int), 128'(0));
    check_eq("hz_vec_flushed", 128'(hz_vec), 128'(0));
    step();

    // End-of-program halt.
    dn_if.ready = 1'b1;
    e = rand_entry();
    e.ctrl.flagEnd = 1'b1;
    drive(e);
    step();
    drive(rand_entry());
    @(negedge clk);
    check_eq("end_pre_ready", 128'(up_if.ready), 128'(1));
    check_eq("end_pre_seen", 128'(end_seen), 128'(0));
    step();
    drive(rand_entry());
    @(negedge clk);
    check_eq("end_seen", 128'(end_seen), 128'(1));
    check_eq("end_ready", 128'(up_if.ready), 128'(0));
    step(); step(); step();
    @(negedge clk);
    check_eq("end_hold_ready", 128'(up_if.ready), 128'(0));
    check_eq("end_hold_seen", 128'(end_seen), 128'(1));
    check_eq("end_drained", 128'(dn_if.valid), 128'(0));
    check_eq("end_sb", 128'(sb_q.size()), 128'(0));
    step();
    up_if.valid = 1'b0;

    // Reset with two entries held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    dn_if.ready = 1'b0;
    drive(rand_entry());
    step();
    drive(rand_entry());
    step();
    up_if.valid = 1'b0;
    @(negedge clk);
    check_eq("rst2_pre_valid", 128'(dn_if.valid), 128'(1));
    check_eq("rst2_pre_full", 128'(up_if.ready), 128'(0));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dn_if.ready = 1'b1;
    @(negedge clk);
    exp_ctrl = '0; exp_ctrl.flagNop = 1'b1;
    check_eq("rst2_valid", 128'(dn_if.valid), 128'(0));
    check_eq("rst2_ready", 128'(up_if.ready), 128'(1));
    check_eq("rst2_stall", 128'(stall_cnt), 128'(0));
    check_eq("rst2_end", 128'(end_seen), 128'(0));
    check_eq("rst2_ctrl", 128'(dn_if.ctrl), 128'(exp_ctrl));
    step(); step();
    check_eq("rst2_no_output", 128'(dn_if.valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
